// File: rtl/ttpu_pkg.sv
// Shared types and saturation helpers for the partial-sum accumulator path.
package ttpu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ACC_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } psum_state_t;

  function automatic logic signed [63:0] SAT_MAX(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] SAT_MIN(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/psum_requant.sv
// Per-lane bias add, arithmetic right shift and signed saturation (combinational).
// Rounding to nearest (half up) is enabled by defining PSUM_ROUND_NEAREST_EN.
module psum_requant
  import ttpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic        [4:0]            shift,
  output logic signed [DATA_WIDTH-1:0] result
);

  // Two guard bits: one for the bias add, one for the rounding add.
  localparam int SUM_W = ACC_WIDTH + 2;
  localparam logic [5:0] SHIFT_MAX = 6'(ACC_WIDTH - 1);
  localparam logic signed [SUM_W-1:0] HI = SUM_W'(SAT_MAX(DATA_WIDTH));
  localparam logic signed [SUM_W-1:0] LO = SUM_W'(SAT_MIN(DATA_WIDTH));

  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [SUM_W-1:0] v);
    if (v > HI) return HI[DATA_WIDTH-1:0];
    if (v < LO) return LO[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
  endfunction

  logic        [5:0]       eff_shift;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] rnd;
  logic signed [SUM_W-1:0] shifted;

  always_comb begin
    eff_shift = ({1'b0, shift} > SHIFT_MAX) ? SHIFT_MAX : {1'b0, shift};
    sum = $signed({{2{acc[ACC_WIDTH-1]}}, acc})
        + $signed({{(SUM_W - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias});
    rnd = '0;
`ifdef PSUM_ROUND_NEAREST_EN
    if (eff_shift != 6'd0) rnd = SUM_W'(1) << (eff_shift - 6'd1);
`else
    rnd = '0;
`endif
    shifted = (sum + rnd) >>> eff_shift;
    result  = saturate(shifted);
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates partial-sum vectors over K-tiles, then bias/requantizes into a held result.
// Optional round-to-nearest requantization: define PSUM_ROUND_NEAREST_EN.
module psum_accumulator
  import ttpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
  parameter int LENGTH     = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic        [CNT_WIDTH-1:0]  tile_count,
  input  logic        [4:0]            shift,
  input  logic signed [DATA_WIDTH-1:0] bias [LENGTH],
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [ACC_WIDTH-1:0]  In [LENGTH],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] Out [LENGTH]
);

  psum_state_t                  state;
  logic        [CNT_WIDTH-1:0]  cnt;
  logic        [CNT_WIDTH-1:0]  target;
  logic        [CNT_WIDTH-1:0]  count_eff;
  logic        [CNT_WIDTH-1:0]  cnt_inc;
  logic                         beat;
  logic                         last_beat;
  logic signed [ACC_WIDTH-1:0]  acc_p0   [LENGTH];
  logic signed [ACC_WIDTH-1:0]  acc_next [LENGTH];
  logic signed [DATA_WIDTH-1:0] req      [LENGTH];

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign beat      = in_valid && in_ready;
  assign count_eff = (tile_count == '0) ? CNT_WIDTH'(1) : tile_count;
  assign cnt_inc   = cnt + CNT_WIDTH'(1);
  assign last_beat = beat && (((state == IDLE)  && (count_eff == CNT_WIDTH'(1))) ||
                              ((state == ACCUM) && (cnt_inc == target)));

  // The first beat of a group overwrites the accumulator rather than adding.
  always_comb begin
    for (int i = 0; i < LENGTH; i++) begin
      acc_next[i] = (state == ACCUM) ? acc_p0[i] + In[i] : In[i];
    end
  end

  for (genvar g = 0; g < LENGTH; g++) begin : g_lane
    psum_requant #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_requant (
      .acc   (acc_next[g]),
      .bias  (bias[g]),
      .shift (shift),
      .result(req[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      target    <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            target <= count_eff;
            cnt    <= CNT_WIDTH'(1);
            if (last_beat) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            cnt <= cnt_inc;
            if (last_beat) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0 -> output: accumulator update or finalized result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LENGTH; i++) begin
        acc_p0[i] <= '0;
        Out[i]    <= '0;
      end
    end else if (!clear && beat) begin
      for (int i = 0; i < LENGTH; i++) begin
        if (last_beat) Out[i] <= req[i];
        else           acc_p0[i] <= acc_next[i];
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with LENGTH=4, DATA_WIDTH=16, ACC_WIDTH=32.
module tb_psum_accumulator;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int L  = 4;
  localparam int CW = 8;

  logic                 clk;
  logic                 reset;
  logic                 clear;
  logic        [CW-1:0] tile_count;
  logic        [4:0]    shift;
  logic signed [DW-1:0] bias [L];
  logic                 in_valid;
  logic                 in_ready;
  logic signed [AW-1:0] In [L];
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] Out [L];

  int passed;
  int total;

  psum_accumulator #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .LENGTH    (L),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .tile_count(tile_count),
    .shift     (shift),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In        (In),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, "_lane0"}, Out[0], e0);
    chk({tag, "_lane1"}, Out[1], e1);
    chk({tag, "_lane2"}, Out[2], e2);
    chk({tag, "_lane3"}, Out[3], e3);
  endtask

  task automatic set_in(input int a, input int b, input int c, input int d);
    In[0] = a; In[1] = b; In[2] = c; In[3] = d;
  endtask

  task automatic set_bias(input int a, input int b, input int c, input int d);
    bias[0] = 16'(a); bias[1] = 16'(b); bias[2] = 16'(c); bias[3] = 16'(d);
  endtask

  initial begin
    int round_lane2;
    passed     = 0;
    total      = 0;
    reset      = 1'b0;
    clear      = 1'b0;
    tile_count = '0;
    shift      = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    set_in(0, 0, 0, 0);
    set_bias(0, 0, 0, 0);
`ifdef PSUM_ROUND_NEAREST_EN
    round_lane2 = 2;
`else
    round_lane2 = 1;
`endif

    // Reset / idle
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk_out("rst_out", 0, 0, 0, 0);
    reset = 1'b1;
    tick();

    // Accumulate three beats with bubbles; tile_count changes after the first beat
    tile_count = 8'd3;
    set_in(10, -5, 7, 0);
    in_valid = 1'b1;
    tick();
    tile_count = 8'd1;
    chk("acc_b1_ready", in_ready, 1);
    chk("acc_b1_valid", out_valid, 0);
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    chk("acc_b2_valid", out_valid, 0);
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("acc_out_valid", out_valid, 1);
    chk_out("acc_out", 30, -15, 21, 0);
    tick();
    chk("acc_done_valid", out_valid, 0);

    // Asynchronous reset mid-group clears Out immediately
    tile_count = 8'd2;
    set_in(5, 5, 5, 5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk_out("arst_out", 0, 0, 0, 0);
    #1;
    reset = 1'b1;

    // Bias, shift and rounding with a single-beat group
    tile_count = 8'd1;
    set_in(100, -100, 7, -7);
    set_bias(4, 4, 0, 0);
    shift = 5'd2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bias_out_valid", out_valid, 1);
    chk_out("bias_out", 26, -24, round_lane2, -2);
    tick();
    chk("bias_done_valid", out_valid, 0);

    // Saturation with back-to-back beats, result held under backpressure
    out_ready  = 1'b0;
    tile_count = 8'd2;
    set_in(40000, -40000, 32767, -32768);
    set_bias(0, 0, 0, 0);
    shift = 5'd0;
    in_valid = 1'b1;
    tick();
    tick();
    chk("sat_out_valid", out_valid, 1);
    chk_out("sat_out", 32767, -32768, 32767, -32768);
    tile_count = 8'd1;
    set_in(1, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_lane0", Out[0], 32767);
      chk("bp_lane3", Out[3], -32768);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("next_out_valid", out_valid, 1);
    chk_out("next_out", 1, 1, 1, 1);
    tick();
    chk("next_done_valid", out_valid, 0);

    // Clear aborts a four-beat group after two beats, even with a beat pending
    tile_count = 8'd4;
    set_in(50, 50, 50, 50);
    in_valid = 1'b1;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    chk_out("clr_out_kept", 1, 1, 1, 1);
    tick();
    chk("clr_idle_valid", out_valid, 0);
    tile_count = 8'd1;
    set_in(1, 2, 3, 4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_clr_valid", out_valid, 1);
    chk_out("post_clr_out", 1, 2, 3, 4);
    tick();

    // tile_count of zero behaves as a single-beat group
    tile_count = 8'd0;
    set_in(-3, 9, -9, 3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("tc0_out_valid", out_valid, 1);
    chk_out("tc0_out", -3, 9, -9, 3);
    tick();
    chk("tc0_done_valid", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
